apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, address width of the core and APB sides.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-004 SHALL have one clock and one reset: clk_i and rst_ni; rst_ni is synchronous and active-low.
REQ-005 SHALL have ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_i  in  1  core request
- gnt_o  out  1  request accepted this cycle
- addr_i  in  APB_ADDR_WIDTH  byte address
- we_i  in  1  write enable
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, one-cycle pulse
- rdata_o  out  32  read data
- err_o  out  1  error, qualified by rvalid_o
- paddr_o  out  APB_ADDR_WIDTH  APB address
- pwdata_o  out  32  APB write data
- pwrite_o  out  1  APB write
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- prdata_i  in  32  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

Function
REQ-006 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-007 SHALL drive gnt_o = req_i combinationally in IDLE and RESP, and 0 in SETUP and ACCESS.
REQ-008 SHALL, on gnt_o, register paddr_o = {addr_i[MSB:2], 2'b00}, pwdata_o = wdata_i and pwrite_o = we_i, then go to SETUP.
REQ-009 SHALL, on a granted write with be_i != 4'hF, start no APB transfer, go to RESP and return err_o = 1.
REQ-010 SHALL drive psel_o = 1 and penable_o = 0 in SETUP for exactly one cycle, then go to ACCESS.
REQ-011 SHALL drive psel_o = 1 and penable_o = 1 in ACCESS, holding paddr_o, pwdata_o and pwrite_o stable until pready_i = 1.
REQ-012 SHALL, on pready_i in ACCESS:
- register rdata_o = prdata_i for reads, or 0 for writes;
- register err_o = pslverr_i;
- go to RESP.
REQ-013 SHALL pulse rvalid_o = 1 for exactly one cycle in RESP; rdata_o and err_o are valid only in that cycle.
REQ-014 SHALL, in RESP, go to SETUP if a new request is granted, otherwise to IDLE, giving back-to-back throughput of one transfer per 3 cycles.
REQ-015 SHALL have zero-wait-state latency: grant at cycle N, SETUP at N+1, ACCESS at N+2, rvalid_o at N+3.
REQ-016 SHALL use a timeout counter of width $clog2(TIMEOUT_CYCLES+1) that clears on entering ACCESS and increments each ACCESS cycle without pready_i.
REQ-017 SHALL, when the counter equals TIMEOUT_CYCLES - 1 with pready_i = 0, drop psel_o and penable_o next cycle, enter RESP and return err_o = 1 and rdata_o = 0.
REQ-018 SHALL give pready_i priority over the timeout when both occur in the same cycle.
REQ-019 SHALL keep psel_o and penable_o at 0 in IDLE and RESP.
REQ-020 SHALL ignore prdata_i, pready_i and pslverr_i outside ACCESS.

Reset
REQ-021 SHALL, while rst_ni = 0 at a clock edge, set the state to IDLE, the counter to 0 and all outputs to 0; gnt_o is 0 during reset.
REQ-022 SHALL, on reset during SETUP or ACCESS, deassert psel_o and penable_o at that edge and emit no rvalid_o for the aborted transfer.

Structure
REQ-023 SHALL take the state enum and the read data returned on timeout (0) from the shared package apb_bridge_pkg.
REQ-024 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-025 SHALL verify a read to 0x1A10_0004 with a zero-wait slave returning 0xCAFE_F00D: gnt at N, psel_o at N+1, penable_o at N+2, rvalid_o at N+3 with rdata_o = 0xCAFE_F00D and err_o = 0.
REQ-026 SHALL verify a write of 0x1234_5678 to 0x1A10_1003 with 3 wait states: paddr_o = 0x1A10_1000 and pwdata_o held stable for 4 ACCESS cycles, then rvalid_o with err_o = 0.
REQ-027 SHALL verify a write with be_i = 4'h3: psel_o never asserted and rvalid_o one cycle after gnt_o with err_o = 1.
REQ-028 SHALL verify TIMEOUT_CYCLES = 4 with pready_i held at 0: ACCESS lasts exactly 4 cycles, then rvalid_o with err_o = 1 and rdata_o = 0.
REQ-029 SHALL verify a read with pslverr_i = 1 on pready_i: err_o = 1, followed by a back-to-back request granted in RESP entering SETUP the next cycle.
REQ-030 SHALL verify rst_ni = 0 asserted during ACCESS: psel_o = 0 at the next edge, no rvalid_o, and gnt_o resumes after release.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the core-to-APB master bridge.
// Holds the bridge FSM encoding and the read data returned on timeout.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

    function automatic logic is_partial_write(input logic we, input logic [3:0] be);
        return we && (be != 4'hF);
    endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Core request/grant port to APB master bridge, one transfer in flight.
// Partial writes are refused locally; stuck slaves are cut off by a timeout.
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [3:0]                be_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [APB_ADDR_WIDTH-1:0] WORD_MASK = ~APB_ADDR_WIDTH'(3);

    state_e                    state_q, state_d;
    logic [TO_W-1:0]           cnt_q, cnt_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      gnt_d;
    logic                      timeout;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        gnt_d    = 1'b0;
        timeout  = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST) && !pready_i;

        unique case (state_q)
            IDLE, RESP: begin
                gnt_d = req_i;
                if (req_i) begin
                    paddr_d  = addr_i & WORD_MASK;
                    pwdata_d = wdata_i;
                    pwrite_d = we_i;
                    // Sub-word writes cannot be expressed on this APB, refuse them
                    if (is_partial_write(we_i, be_i)) begin
                        state_d = RESP;
                        rdata_d = TIMEOUT_RDATA;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SETUP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (pready_i) begin
                    state_d = RESP;
                    rdata_d = pwrite_q ? '0 : prdata_i;
                    err_d   = pslverr_i;
                end else if (timeout) begin
                    state_d = RESP;
                    rdata_d = TIMEOUT_RDATA;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign gnt_o     = gnt_d & rst_ni;
    assign psel_o    = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o = (state_q == ACCESS);
    assign rvalid_o  = (state_q == RESP);
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign pwrite_o  = pwrite_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized self-checking bench for apb_master_bridge with a
// transaction-level latency/response model and a reactive APB slave.
module tb_apb_master_bridge;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_checks = 0;
    int n_errors = 0;

    apb_master_bridge #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .gnt_o    (gnt),
        .addr_i   (addr),
        .we_i     (we),
        .be_i     (be),
        .wdata_i  (wdata),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err),
        .paddr_o  (paddr),
        .pwdata_o (pwdata),
        .pwrite_o (pwrite),
        .psel_o   (psel),
        .penable_o(penable),
        .prdata_i (prdata),
        .pready_i (pready),
        .pslverr_i(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("idle_rvalid", {31'b0, rvalid}, 32'd0);
            chk("idle_psel", {31'b0, psel}, 32'd0);
        end
    endtask

    // One core transaction; waits < 0 means the slave never answers.
    // Entered and left one time unit after a rising edge.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] wd, input int waits,
                        input logic serr, input logic [31:0] prd);
        bit          be_err;
        bit          to;
        int          exp_acc;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_addr;
        int          acc;
        int          cyc;
        int          psel_n;
        int          bad;
        bit          done;
        be_err   = w && (b != 4'hF);
        to       = (waits < 0) || (waits + 1 > TO);
        exp_acc  = be_err ? 0 : (to ? TO : waits + 1);
        exp_lat  = be_err ? 1 : 2 + exp_acc;
        exp_rd   = (be_err || to || w) ? 32'h0 : prd;
        exp_err  = be_err || to || serr;
        exp_addr = a & 32'hFFFF_FFFC;
        acc = 0;
        cyc = 1;
        psel_n = 0;
        bad = 0;
        done = 0;
        pready = 1'b0;
        req = 1'b1;
        addr = a;
        we = w;
        be = b;
        wdata = wd;
        @(negedge clk);
        chk("gnt", {31'b0, gnt}, 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0;
        addr = $urandom;
        we = 1'($urandom);
        be = 4'($urandom);
        wdata = $urandom;
        while (!done && cyc < 40) begin
            if (rvalid) begin
                done = 1;
                chk("latency", cyc, exp_lat);
                chk("rdata", rdata, exp_rd);
                chk("err", {31'b0, err}, {31'b0, exp_err});
            end else begin
                if (psel) begin
                    psel_n++;
                    if (paddr !== exp_addr || pwdata !== wd || pwrite !== w)
                        bad++;
                end
                if (psel && penable) begin
                    acc++;
                    pready = (waits >= 0) && (acc == waits + 1);
                    prdata = pready ? prd : $urandom;
                    pslverr = pready ? serr : 1'($urandom);
                end else begin
                    pready = 1'($urandom);
                    prdata = $urandom;
                    pslverr = 1'($urandom);
                end
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!done) chk("rvalid_seen", 32'd0, 32'd1);
        chk("access_cycles", acc, exp_acc);
        chk("psel_cycles", psel_n, be_err ? 0 : exp_acc + 1);
        chk("bus_stable", bad, 0);
        pready = 1'b0;
    endtask

    initial begin
        int waits;
        logic [3:0] b;
        rst_n = 1'b0;
        req = 1'b1;
        addr = 32'h1A10_0004;
        we = 1'b0;
        be = 4'hF;
        wdata = 32'h0;
        prdata = 32'hDEAD_BEEF;
        pready = 1'b1;
        pslverr = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", {31'b0, gnt}, 32'd0);
        chk("rst_psel", {31'b0, psel}, 32'd0);
        chk("rst_penable", {31'b0, penable}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        rst_n = 1'b1;
        req = 1'b0;
        pready = 1'b0;
        idle(2);

        xfer(32'h1A10_0004, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
        idle(1);
        xfer(32'h1A10_1003, 1'b1, 4'hF, 32'h1234_5678, 3, 1'b0, 32'h5555_AAAA);
        idle(1);
        xfer(32'h1A10_2000, 1'b1, 4'h3, 32'hFFFF_0000, 0, 1'b0, 32'h0);
        idle(1);
        xfer(32'h1A10_3008, 1'b0, 4'hF, 32'h0, -1, 1'b0, 32'h7777_7777);
        idle(1);
        xfer(32'h1A10_400C, 1'b0, 4'hF, 32'h0, 1, 1'b1, 32'h0BAD_0BAD);
        xfer(32'h1A10_5010, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h600D_600D);
        xfer(32'h1A10_6014, 1'b1, 4'h1, 32'h1, 0, 1'b0, 32'h0);
        xfer(32'h1A10_7018, 1'b0, 4'hF, 32'h0, 4, 1'b0, 32'h1111_2222);
        idle(1);

        req = 1'b1;
        addr = 32'h1A10_0020;
        we = 1'b0;
        be = 4'hF;
        @(negedge clk);
        chk("rst_seq_gnt", {31'b0, gnt}, 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_seq_access", {31'b0, penable}, 32'd1);
        rst_n = 1'b0;
        req = 1'b1;
        pready = 1'b1;
        prdata = 32'hABCD_1234;
        @(posedge clk);
        #1;
        chk("rst_seq_psel", {31'b0, psel}, 32'd0);
        chk("rst_seq_penable", {31'b0, penable}, 32'd0);
        chk("rst_seq_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_seq_gnt_low", {31'b0, gnt}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_seq_rvalid2", {31'b0, rvalid}, 32'd0);
        rst_n = 1'b1;
        req = 1'b0;
        pready = 1'b0;
        idle(2);
        xfer(32'h1A10_0024, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h4242_4242);

        for (int i = 0; i < 40; i++) begin
            waits = $urandom_range(0, 6);
            if (waits == 6) waits = -1;
            b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            xfer($urandom, 1'($urandom), b, $urandom, waits, 1'($urandom), $urandom);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end

        idle(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
